// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: condition codes, flag bit positions
// and 2-bit saturating counter states.
package branch_pkg;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_VS     = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT       = 2'd0;
    localparam ctr_t WNT       = 2'd1;
    localparam ctr_t WT        = 2'd2;
    localparam ctr_t ST        = 2'd3;
    localparam ctr_t CNT_RESET = WNT;

    function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != ST) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluation: condition code plus {Z,V,N} flags
// give the branch direction.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [2:0] flags_i,
    output logic       taken_o
);

    logic z;
    logic v;
    logic n;

    assign z = flags_i[FLAG_Z];
    assign v = flags_i[FLAG_V];
    assign n = flags_i[FLAG_N];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_NEQ:    taken_o = !z;
            COND_EQ:     taken_o = z;
            COND_GT:     taken_o = !z && !n;
            COND_LT:     taken_o = n;
            COND_GE:     taken_o = z || (!z && !n);
            COND_LE:     taken_o = n || z;
            COND_VS:     taken_o = v;
            COND_UNCOND: taken_o = 1'b1;
            default:     taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution and direction prediction: flag register with write
// forwarding, one-cycle resolve pipeline and a 2-bit counter BHT.
module branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16,
    parameter int PC_INC    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      flag_we,
    input  logic [2:0]      flag_in,
    output logic [2:0]      flags_out,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_target,
    input  logic            br_pred_taken,
    input  logic            flush,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic [PC_W-1:0] res_redirect_pc
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [2:0]       flags_q;
    logic [2:0]       flags_d;
    logic             eval_taken;
    logic             accept;
    logic             train;

    logic             res_valid_q;
    logic             res_taken_q;
    logic             res_mis_q;
    logic [PC_W-1:0]  res_redirect_q;
    logic [IDX_W-1:0] res_idx_q;
    logic [PC_W-1:0]  res_redirect_d;

    ctr_t             bht_q [BHT_DEPTH];

    // Same-cycle flag writes feed condition evaluation directly.
    assign flags_d = (flag_we & flag_in) | (~flag_we & flags_q);

    branch_cond_eval u_cond_eval (
        .cond_i  (br_cond),
        .flags_i (flags_d),
        .taken_o (eval_taken)
    );

    assign accept         = br_valid && !flush;
    assign train          = res_valid_q && !flush;
    assign res_redirect_d = eval_taken ? br_target : br_pc + PC_W'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Payload only loads on an accepted branch and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q    <= 1'b0;
            res_taken_q    <= 1'b0;
            res_mis_q      <= 1'b0;
            res_redirect_q <= '0;
            res_idx_q      <= '0;
        end else begin
            res_valid_q <= accept;
            if (accept) begin
                res_taken_q    <= eval_taken;
                res_mis_q      <= eval_taken ^ br_pred_taken;
                res_redirect_q <= res_redirect_d;
                res_idx_q      <= br_pc[IDX_W:1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CNT_RESET;
            end
        end else if (train) begin
            bht_q[res_idx_q] <= ctr_update(bht_q[res_idx_q], res_taken_q);
        end
    end

    // Prediction reads the counter array before any same-cycle training.
    assign pred_taken = bht_q[pred_pc[IDX_W:1]][1];

    logic unused_pred_bits;
    assign unused_pred_bits = ^{pred_pc[PC_W-1:IDX_W+1], pred_pc[0]};

    assign flags_out       = flags_q;
    assign res_valid       = res_valid_q && !flush;
    assign res_taken       = res_taken_q;
    assign res_mispredict  = res_mis_q;
    assign res_redirect_pc = res_redirect_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_branch_unit;

    localparam int PC_W   = 16;
    localparam int DEPTH  = 16;
    localparam int PC_INC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      flag_we;
    logic [2:0]      flag_in;
    logic [2:0]      flags_out;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] br_target;
    logic            br_pred_taken;
    logic            flush;
    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic [PC_W-1:0] res_redirect_pc;

    logic [2:0] ce_cond;
    logic [2:0] ce_flags;
    logic       ce_taken;

    always #5 clk = ~clk;

    branch_unit #(.PC_W(PC_W), .BHT_DEPTH(DEPTH), .PC_INC(PC_INC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flag_we         (flag_we),
        .flag_in         (flag_in),
        .flags_out       (flags_out),
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .br_valid        (br_valid),
        .br_cond         (br_cond),
        .br_pc           (br_pc),
        .br_target       (br_target),
        .br_pred_taken   (br_pred_taken),
        .flush           (flush),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_mispredict  (res_mispredict),
        .res_redirect_pc (res_redirect_pc)
    );

    branch_cond_eval u_ce (
        .cond_i  (ce_cond),
        .flags_i (ce_flags),
        .taken_o (ce_taken)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [2:0]      m_flags;
    int              m_bht [DEPTH];
    bit              m_pv;
    bit              m_pt;
    bit              m_pm;
    logic [PC_W-1:0] m_pr;
    int              m_pidx;

    typedef struct {
        logic [2:0]      fin;
        logic [2:0]      cond;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] tgt;
        logic            pred;
        logic            exp_taken;
        logic            exp_mis;
        logic [PC_W-1:0] exp_redir;
    } vec_t;

    vec_t vecs [13];

    function automatic bit ref_cond(input int c, input bit z, input bit v, input bit n);
        bit gt;
        gt = !z && !n;
        case (c)
            0: return !z;
            1: return z;
            2: return gt;
            3: return n;
            4: return z || gt;
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int idx_of(input logic [PC_W-1:0] pc);
        return (int'(pc) / 2) % DEPTH;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = 3'b000;
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_pv = 0; m_pt = 0; m_pm = 0; m_pr = '0; m_pidx = 0;
    endtask

    task automatic set_idle();
        br_valid = 0; flush = 0; flag_we = 3'b000; flag_in = 3'b000;
        br_cond = 3'b000; br_pc = '0; br_target = '0; br_pred_taken = 0;
    endtask

    task automatic set_branch(input logic [2:0] we, input logic [2:0] fin, input logic [2:0] c,
                              input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                              input logic pred, input logic fl);
        br_valid = 1; flag_we = we; flag_in = fin; br_cond = c;
        br_pc = pc; br_target = tgt; br_pred_taken = pred; flush = fl;
    endtask

    // One clock: check every output against the model, then advance the model at the edge.
    task automatic cycle();
        logic [2:0] ef;
        bit         tk;
        #1;
        check("flags_out", 32'(flags_out), 32'(m_flags));
        check("pred_taken", 32'(pred_taken), 32'(m_bht[idx_of(pred_pc)] >= 2));
        check("res_valid", 32'(res_valid), 32'(m_pv && !flush));
        check("res_taken", 32'(res_taken), 32'(m_pt));
        check("res_mispredict", 32'(res_mispredict), 32'(m_pm));
        check("res_redirect_pc", 32'(res_redirect_pc), 32'(m_pr));
        ef = (flag_we & flag_in) | (~flag_we & m_flags);
        @(posedge clk);
        if (m_pv && !flush) begin
            if (m_pt) m_bht[m_pidx] = (m_bht[m_pidx] + 1 > 3) ? 3 : m_bht[m_pidx] + 1;
            else      m_bht[m_pidx] = (m_bht[m_pidx] - 1 < 0) ? 0 : m_bht[m_pidx] - 1;
        end
        m_pv = br_valid && !flush;
        if (m_pv) begin
            tk     = ref_cond(int'(br_cond), ef[2], ef[1], ef[0]);
            m_pt   = tk;
            m_pm   = tk ^ br_pred_taken;
            m_pr   = tk ? br_target : br_pc + PC_W'(PC_INC);
            m_pidx = idx_of(br_pc);
        end
        m_flags = ef;
        #1;
    endtask

    initial begin
        // {fin Z,V,N, cond, pc, target, pred, taken, mispredict, redirect}
        vecs[0]  = '{3'b000, 3'b000, 16'h0100, 16'h0200, 1'b0, 1'b1, 1'b1, 16'h0200};
        vecs[1]  = '{3'b100, 3'b000, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 16'h0102};
        vecs[2]  = '{3'b000, 3'b010, 16'h0104, 16'h0300, 1'b1, 1'b1, 1'b0, 16'h0300};
        vecs[3]  = '{3'b001, 3'b010, 16'h0104, 16'h0300, 1'b1, 1'b0, 1'b1, 16'h0106};
        vecs[4]  = '{3'b001, 3'b011, 16'h0008, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234};
        vecs[5]  = '{3'b000, 3'b100, 16'h0020, 16'h0050, 1'b1, 1'b1, 1'b0, 16'h0050};
        vecs[6]  = '{3'b001, 3'b100, 16'h0020, 16'h0050, 1'b0, 1'b0, 1'b0, 16'h0022};
        vecs[7]  = '{3'b100, 3'b101, 16'h0030, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0010};
        vecs[8]  = '{3'b010, 3'b110, 16'h0040, 16'hABCE, 1'b1, 1'b1, 1'b0, 16'hABCE};
        vecs[9]  = '{3'b101, 3'b110, 16'h7FFE, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h8000};
        vecs[10] = '{3'b000, 3'b111, 16'h0002, 16'hFFFE, 1'b0, 1'b1, 1'b1, 16'hFFFE};
        vecs[11] = '{3'b000, 3'b001, 16'hFFFE, 16'h1000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[12] = '{3'b000, 3'b001, 16'hFFFE, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h0000};

        // Reset held with a branch and flag writes driven
        rst_n = 0;
        pred_pc = '0;
        ce_cond = '0; ce_flags = '0;
        set_branch(3'b111, 3'b111, 3'b111, 16'h0010, 16'h0040, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset flags_out", 32'(flags_out), 32'd0);
        check("reset res_redirect_pc", 32'(res_redirect_pc), 32'd0);
        check("reset res_taken", 32'(res_taken), 32'd0);
        set_idle();
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) begin
            pred_pc = PC_W'(2 * i + 32 * (i % 3));
            #1;
            check("reset pred_taken", 32'(pred_taken), 32'd0);
        end
        cycle();

        // Saturation at 0x0010: four taken branches back to back
        pred_pc = 16'h0010;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_branch(3'b000, 3'b000, 3'b111, 16'h0010, 16'h0080, 1'b0, 1'b0);
            else       set_idle();
            #1;
            check("sat pred seq", 32'(pred_taken), (k < 2) ? 32'd0 : 32'd1);
            cycle();
        end
        // Two not-taken resolutions: 3 -> 2 keeps taken, 2 -> 1 drops it
        for (int k = 0; k < 2; k++) begin
            set_branch(3'b111, 3'b100, 3'b000, 16'h0010, 16'h0080, 1'b1, 1'b0);
            cycle();
            set_idle();
            cycle();
            #1;
            check("nt pred", 32'(pred_taken), (k == 0) ? 32'd1 : 32'd0);
        end

        // Flush in the issue cycle: dropped, counter untouched, flags still written
        set_branch(3'b111, 3'b010, 3'b111, 16'h0010, 16'h0080, 1'b0, 1'b1);
        cycle();
        set_idle();
        #1;
        check("issue flush res_valid", 32'(res_valid), 32'd0);
        check("issue flush flags", 32'(flags_out), 32'b010);
        cycle();
        #1;
        check("issue flush pred", 32'(pred_taken), 32'd0);
        // Flush in the resolve cycle
        set_branch(3'b000, 3'b000, 3'b111, 16'h0010, 16'h0080, 1'b0, 1'b0);
        cycle();
        set_idle();
        flush = 1;
        #1;
        check("resolve flush res_valid", 32'(res_valid), 32'd0);
        cycle();
        flush = 0;
        #1;
        check("resolve flush pred", 32'(pred_taken), 32'd0);
        cycle();

        // Forwarding: clear flags, then write Z in the same cycle as cond EQ
        flag_we = 3'b111; flag_in = 3'b000;
        cycle();
        set_branch(3'b100, 3'b100, 3'b001, 16'h0060, 16'h0040, 1'b0, 1'b0);
        cycle();
        set_idle();
        #1;
        check("fwd res_valid", 32'(res_valid), 32'd1);
        check("fwd res_taken", 32'(res_taken), 32'd1);
        check("fwd redirect", 32'(res_redirect_pc), 32'h0040);
        check("fwd flags_out", 32'(flags_out), 32'b100);
        cycle();

        // Vector table
        for (int i = 0; i < 13; i++) begin
            set_branch(3'b111, vecs[i].fin, vecs[i].cond, vecs[i].pc, vecs[i].tgt, vecs[i].pred, 1'b0);
            cycle();
            set_idle();
            #1;
            check($sformatf("vec%0d res_valid", i), 32'(res_valid), 32'd1);
            check($sformatf("vec%0d res_taken", i), 32'(res_taken), 32'(vecs[i].exp_taken));
            check($sformatf("vec%0d res_mispredict", i), 32'(res_mispredict), 32'(vecs[i].exp_mis));
            check($sformatf("vec%0d redirect", i), 32'(res_redirect_pc), 32'(vecs[i].exp_redir));
        end
        cycle();

        // Condition sweep on the evaluator alone and back to back through the unit
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                ce_cond = 3'(c); ce_flags = 3'(f);
                #1;
                check($sformatf("cond_eval c%0d f%0d", c, f), 32'(ce_taken),
                      32'(ref_cond(c, f[2], f[1], f[0])));
                set_branch(3'b111, 3'(f), 3'(c), PC_W'($urandom_range(0, 65535)) & 16'hFFFE,
                           PC_W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0);
                cycle();
            end
        end
        set_idle();
        cycle();

        // Reset with a resolution pending
        set_branch(3'b000, 3'b000, 3'b111, 16'h0012, 16'h0090, 1'b0, 1'b0);
        cycle();
        set_idle();
        rst_n = 0;
        #1;
        check("mid reset res_valid", 32'(res_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            br_valid      = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 7) == 0);
            flag_we       = 3'($urandom_range(0, 7));
            flag_in       = 3'($urandom_range(0, 7));
            br_cond       = 3'($urandom_range(0, 7));
            br_pc         = ($urandom_range(0, 3) == 0) ? 16'hFFFE
                            : PC_W'($urandom_range(0, 65535)) & 16'hFFFE;
            br_target     = PC_W'($urandom_range(0, 65535));
            br_pred_taken = 1'($urandom_range(0, 1));
            pred_pc       = PC_W'($urandom_range(0, 65535));
            cycle();
        end
        set_idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
